// File: rtl/fifo_stream_reader_if.sv
// Handshake bundle between the show-ahead FIFO, the stream reader and the downstream sink.
// The master modport is the reader; the slave modport is the FIFO/sink side.
interface fifo_stream_reader_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_rd_en;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  modport master (
    input  fifo_empty, fifo_data, out_ready,
    output fifo_rd_en, out_valid, out_data, out_last
  );

  modport slave (
    output fifo_empty, fifo_data, out_ready,
    input  fifo_rd_en, out_valid, out_data, out_last
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Pops words from a show-ahead FIFO into a hold/output pipeline and packetizes them,
// closing a packet after PKT_LEN words or after TIMEOUT idle cycles with a word held.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 4,
  parameter int TIMEOUT    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  fifo_stream_reader_if.master  bus,
  output logic [15:0]           pkt_count
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  localparam logic [7:0] LAST_IDX = 8'(PKT_LEN - 1);
  localparam logic [7:0] IDLE_MAX = 8'(TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic [7:0]            widx_q, widx_d;
  logic [7:0]            idle_cnt_q, idle_cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  logic [15:0]           pkt_count_q, pkt_count_d;

  logic out_free_s;
  logic pop_s;
  logic at_last_s;
  logic flush_s;

  // Pop/flush decisions, next-state for the hold stage, output stage and packet counter.
  always_comb begin
    out_free_s  = !out_valid_q || bus.out_ready;
    pop_s       = !reset && enable && !bus.fifo_empty &&
                  ((state_q == ST_EMPTY) || out_free_s);
    at_last_s   = (widx_q == LAST_IDX);
    // A flush only happens when the pop path is idle, so a pop always wins.
    flush_s     = (state_q == ST_HOLD) && out_free_s && !pop_s &&
                  (at_last_s || (idle_cnt_q == IDLE_MAX));

    state_d     = state_q;
    hold_data_d = hold_data_q;
    widx_d      = widx_q;
    idle_cnt_d  = idle_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    pkt_count_d = pkt_count_q;

    case (state_q)
      ST_EMPTY: begin
        if (pop_s) begin
          state_d     = ST_HOLD;
          hold_data_d = bus.fifo_data;
          widx_d      = 8'd0;
          idle_cnt_d  = 8'd0;
        end else begin
          state_d     = ST_EMPTY;
        end
      end
      ST_HOLD: begin
        if (pop_s) begin
          hold_data_d = bus.fifo_data;
          widx_d      = at_last_s ? 8'd0 : (widx_q + 8'd1);
          idle_cnt_d  = 8'd0;
        end else if (flush_s) begin
          state_d     = ST_EMPTY;
          widx_d      = 8'd0;
          idle_cnt_d  = 8'd0;
        end else if (idle_cnt_q != IDLE_MAX) begin
          idle_cnt_d  = idle_cnt_q + 8'd1;
        end else begin
          idle_cnt_d  = idle_cnt_q;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    if (out_free_s) begin
      if ((state_q == ST_HOLD) && (pop_s || flush_s)) begin
        out_valid_d = 1'b1;
        out_data_d  = hold_data_q;
        out_last_d  = flush_s || at_last_s;
      end else begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    end else begin
      out_valid_d = out_valid_q;
    end

    if (out_valid_q && bus.out_ready && out_last_q) begin
      pkt_count_d = pkt_count_q + 16'd1;
    end else begin
      pkt_count_d = pkt_count_q;
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      hold_data_q <= '0;
      widx_q      <= 8'd0;
      idle_cnt_q  <= 8'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      pkt_count_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      widx_q      <= widx_d;
      idle_cnt_q  <= idle_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign bus.fifo_rd_en = pop_s;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_last   = out_last_q;
  assign pkt_count      = pkt_count_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomized and directed bench for fifo_stream_reader: a queue-based FIFO model feeds the
// DUT and a scoreboard predicts beat order, packet boundaries and the packet count.
module tb_fifo_stream_reader;
  localparam int DW = 8;
  localparam int PL = 4;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] pkt_count;
  logic        reset1;
  logic        enable1;
  logic [15:0] pkt_count1;

  always #5 clk = ~clk;

  fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();
  fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus1 ();

  fifo_stream_reader #(.DATA_WIDTH(DW), .PKT_LEN(PL), .TIMEOUT(TO)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .bus       (bus.master),
    .pkt_count (pkt_count)
  );

  // Single-word-packet instance used for the counter wrap and PKT_LEN=1 behaviour.
  fifo_stream_reader #(.DATA_WIDTH(DW), .PKT_LEN(1), .TIMEOUT(3)) u_dut1 (
    .clk       (clk),
    .reset     (reset1),
    .enable    (enable1),
    .bus       (bus1.master),
    .pkt_count (pkt_count1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int  pos, exp_pkts, beats, pops, edge_no;
  bit  draining;
  bit  wrap_done = 1'b0;
  logic       s_rd, s_ov, s_ol, s_rdy;
  logic [7:0] s_od;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic refresh();
    bus.fifo_empty = (fifo_q.size() == 0);
    bus.fifo_data  = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
  endtask

  task automatic push(input logic [7:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    refresh();
  endtask

  // One clock: sample at the falling edge, score, then apply the FIFO pop after the rising edge.
  task automatic tick();
    bit exp_last;
    @(negedge clk);
    s_rd  = bus.fifo_rd_en;
    s_ov  = bus.out_valid;
    s_od  = bus.out_data;
    s_ol  = bus.out_last;
    s_rdy = bus.out_ready;
    if (s_rd) check_val("pop_nonempty", {31'd0, fifo_q.size() != 0}, 32'd1);
    if (s_ov) begin
      if (exp_q.size() == 0) begin
        check_val("spurious_beat", {31'd0, s_ov}, 32'd0);
      end else begin
        exp_last = (pos == PL - 1) || (draining && exp_q.size() == 1);
        check_val("beat_data", {24'd0, s_od}, {24'd0, exp_q[0]});
        check_val("beat_last", {31'd0, s_ol}, {31'd0, exp_last});
        if (s_rdy) begin
          void'(exp_q.pop_front());
          beats++;
          if (exp_last) begin
            exp_pkts++;
            pos = 0;
          end else begin
            pos++;
          end
        end
      end
    end
    @(posedge clk);
    edge_no++;
    #1;
    if (s_rd && fifo_q.size() != 0) begin
      void'(fifo_q.pop_front());
      pops++;
    end
    refresh();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    check_val("rst_rd_en",     {31'd0, bus.fifo_rd_en}, 32'd0);
    check_val("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_val("rst_out_last",  {31'd0, bus.out_last}, 32'd0);
    check_val("rst_out_data",  {24'd0, bus.out_data}, 32'd0);
    check_val("rst_pkt_count", {16'd0, pkt_count}, 32'd0);
    @(posedge clk);
    edge_no++;
    #1;
    fifo_q.delete();
    exp_q.delete();
    pos = 0; exp_pkts = 0; beats = 0; pops = 0; draining = 1'b0;
    refresh();
    reset = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) check_val({tag, "_drain_timeout"}, 32'd0, 32'd1);
    repeat (12) tick();
  endtask

  initial begin
    int load_edge;
    int rd_seen;
    bit a1_seen;
    int w;
    reset = 1'b1; enable = 1'b0;
    bus.out_ready = 1'b1;
    edge_no = 0;
    refresh();
    do_reset();

    // Streaming of two full packets.
    enable = 1'b1;
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    draining = 1'b1;
    drain("stream");
    check_val("stream_beats", beats, 32'd8);
    check_val("stream_pkts", {16'd0, pkt_count}, 32'd2);

    // Short packet closed by the idle timeout.
    do_reset();
    push(8'hA0); push(8'hA1);
    draining = 1'b1;
    rd_seen = 0; a1_seen = 1'b0; load_edge = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (s_rd) begin
        rd_seen++;
        if (rd_seen == 2) load_edge = edge_no;
      end
      if (s_ov && s_od == 8'hA1 && !a1_seen) begin
        a1_seen = 1'b1;
        check_val("timeout_latency", (edge_no - 1) - load_edge, TO);
      end
    end
    check_val("timeout_seen", {31'd0, a1_seen}, 32'd1);
    check_val("timeout_pkts", {16'd0, pkt_count}, 32'd1);

    // Backpressure: only two words enter the pipeline while the sink stalls.
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'($urandom));
    draining = 1'b1;
    repeat (10) tick();
    check_val("bp_pops", pops, 32'd2);
    check_val("bp_valid", {31'd0, bus.out_valid}, 32'd1);
    drain("bp");
    check_val("bp_beats", beats, 32'd6);
    check_val("bp_pkts", {16'd0, pkt_count}, 32'd2);

    // Enable gating of pops.
    do_reset();
    enable = 1'b0;
    for (int i = 0; i < 5; i++) push(8'($urandom));
    draining = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_val("en_low_no_pop", {31'd0, s_rd}, 32'd0);
    end
    enable = 1'b1;
    tick();
    check_val("en_resume", {31'd0, s_rd}, 32'd1);
    drain("en");
    check_val("en_pkts", {16'd0, pkt_count}, 32'd2);

    // Random backpressure with a never-empty FIFO; only the tail may be short.
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 3; i++) push(8'($urandom));
    for (int i = 0; i < 1500; i++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (fifo_q.size() < 4 && $urandom_range(0, 1) == 1) push(8'($urandom));
      if (fifo_q.size() == 0) push(8'($urandom));
    end
    draining = 1'b1;
    drain("rand");
    check_val("rand_pkts", {16'd0, pkt_count}, exp_pkts);

    // Reset in the middle of traffic discards the pipeline contents.
    for (int i = 0; i < 6; i++) push(8'($urandom));
    repeat (3) tick();
    do_reset();
    repeat (12) tick();

    w = 0;
    while (!wrap_done && w < 80000) begin
      @(posedge clk);
      w++;
    end
    if (!wrap_done) check_val("wrap_done", 32'd0, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // 65536 single-word packets on the PKT_LEN=1 instance wrap its packet counter.
  initial begin
    int beats1;
    int nonlast1;
    int cyc;
    reset1 = 1'b1; enable1 = 1'b0;
    bus1.fifo_empty = 1'b0;
    bus1.fifo_data  = 8'h5A;
    bus1.out_ready  = 1'b1;
    beats1 = 0; nonlast1 = 0; cyc = 0;
    repeat (2) @(posedge clk);
    #1;
    reset1 = 1'b0;
    enable1 = 1'b1;
    while (beats1 < 65536 && cyc < 70000) begin
      @(negedge clk);
      cyc++;
      if (bus1.out_valid) begin
        if (beats1 == 65535) check_val("wrap_ffff", {16'd0, pkt_count1}, 32'h0000FFFF);
        if (!bus1.out_last) nonlast1++;
        beats1++;
      end
      @(posedge clk);
      #1;
    end
    enable1 = 1'b0;
    bus1.out_ready = 1'b0;
    @(negedge clk);
    check_val("wrap_beats", beats1, 32'd65536);
    check_val("wrap_zero", {16'd0, pkt_count1}, 32'd0);
    check_val("len1_all_last", nonlast1, 32'd0);
    wrap_done = 1'b1;
  end

endmodule

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 8, data word width.
REQ-002 SHALL have parameter PKT_LEN, 4, words per full packet; legal range 1..255.
REQ-003 SHALL have parameter TIMEOUT, 8, cycles before a short packet is closed; legal range 1..255.
REQ-004 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port enable  input  1  permits FIFO pops when high.
REQ-007 SHALL have port fifo_empty  input  1  empty flag of the upstream sync FIFO.
REQ-008 SHALL have port fifo_data  input  DATA_WIDTH  FIFO head word, valid combinationally while fifo_empty=0 (show-ahead).
REQ-009 SHALL have port fifo_rd_en  output  1  pop strobe to the FIFO; one word consumed per high cycle.
REQ-010 SHALL have port out_valid  output  1  downstream stream valid.
REQ-011 SHALL have port out_ready  input  1  downstream stream ready.
REQ-012 SHALL have port out_data  output  DATA_WIDTH  downstream stream data.
REQ-013 SHALL have port out_last  output  1  marks final word of a packet.
REQ-014 SHALL have port pkt_count  output  16  count of packets accepted downstream.

Function
REQ-015 SHALL hold words in a two-stage pipeline: hold register (hold_valid, hold_data, widx) then output register (out_valid, out_data, out_last).
REQ-016 SHALL define out_free = !out_valid || out_ready; output register loads only when out_free=1, else out_valid/out_data/out_last are held stable.
REQ-017 SHALL define states EMPTY (hold_valid=0) and HOLD (hold_valid=1); EMPTY->HOLD on pop; HOLD->EMPTY on flush without simultaneous pop; HOLD->HOLD on pop.
REQ-018 SHALL drive fifo_rd_en = enable && !fifo_empty && (!hold_valid || out_free), combinationally.
REQ-019 SHALL, on pop in EMPTY, load fifo_data into hold with widx=0 and leave the output register unchanged by this path.
REQ-020 SHALL, on pop in HOLD, move hold to output with out_last=(widx==PKT_LEN-1) and load fifo_data into hold with widx = (widx==PKT_LEN-1) ? 0 : widx+1.
REQ-021 SHALL full-flush: in HOLD with widx==PKT_LEN-1, out_free=1 and no pop, move hold to output with out_last=1, go to EMPTY.
REQ-022 SHALL count idle_cnt: cleared when hold loads; incremented each HOLD cycle without pop or flush; saturates at TIMEOUT-1.
REQ-023 SHALL timeout-flush: in HOLD with idle_cnt==TIMEOUT-1, out_free=1 and no pop, move hold to output with out_last=1, go to EMPTY; next packet starts at widx=0.
REQ-024 SHALL give a single isolated word out_valid=1 exactly TIMEOUT edges after the edge that loaded hold (out_ready=1, PKT_LEN>1).
REQ-025 SHALL sustain one word per cycle when FIFO non-empty and out_ready=1.
REQ-026 SHALL never flush or pop while out_free=0 and hold_valid=1; no word is dropped or duplicated.
REQ-027 SHALL, with enable=0, stop popping but still perform full- and timeout-flushes of a held word.
REQ-028 SHALL increment pkt_count on each cycle with out_valid && out_ready && out_last; wraps 0xFFFF->0x0000.
REQ-029 SHALL with PKT_LEN=1 emit every word with out_last=1.

Reset
REQ-030 SHALL on reset force out_valid=0, out_data=0, out_last=0, pkt_count=0, hold_valid=0, widx=0, idle_cnt=0, state EMPTY.
REQ-031 SHALL keep fifo_rd_en=0 while reset is high; reset mid-packet discards held and output words.

Verification
REQ-032 SHALL cover reset: assert mid-traffic -> next cycle out_valid=0, pkt_count=0, fifo_rd_en=0.
REQ-033 SHALL cover streaming: 8 words 0x10..0x17 preloaded, out_ready=1, PKT_LEN=4 -> 8 beats, out_last on 0x13 and 0x17, pkt_count=2.
REQ-034 SHALL cover timeout: 2 words 0xA0,0xA1 then empty, TIMEOUT=8 -> 0xA0 last=0; 0xA1 last=1 with out_valid rising 8 edges after 0xA1 loaded hold; pkt_count=1.
REQ-035 SHALL cover backpressure: 6 words, out_ready=0 for 10 cycles -> exactly 2 pops, out_data stable, no flush; release -> all 6 words in order.
REQ-036 SHALL cover enable: enable=0 with 5 words queued -> fifo_rd_en=0 throughout; enable=1 -> pops resume at next cycle.
REQ-037 SHALL cover pkt_count wrap: 65536 single-word packets -> pkt_count returns to 0x0000.
